write_logic_gray: RTL

//   Write-side pointer/flag controller of the asynchronous FIFO, the counterpart of the read-side

---
 rtl/write_logic_gray.sv | 80 ++++++++
 1 files changed

// File: rtl/write_logic_gray.sv
// Write-side pointer/flag controller of an asynchronous FIFO (write clock domain only).
// Gates writes against a registered full flag and derives level flags from a synchronised read pointer.
module write_logic_gray #(
  parameter int depth     = 8,
  parameter int adr_width = $clog2(depth),
  parameter int af_level  = depth - 2
) (
  input  logic                 clk_w,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 ovf_clr,
  input  logic [adr_width:0]   rd_ptr_gray,
  output logic                 write,
  output logic [adr_width:0]   write_adr,
  output logic [adr_width:0]   wr_ptr_gray,
  output logic                 FIFO_full,
  output logic                 almost_full,
  output logic [adr_width:0]   fill_level,
  output logic                 overflow
);

  localparam logic [adr_width:0] af_thresh = (adr_width + 1)'(af_level);

  logic [adr_width:0] wr_bin;
  logic [adr_width:0] bin_next;
  logic [adr_width:0] gray_next;
  logic [adr_width:0] rq1;
  logic [adr_width:0] rq2;
  logic [adr_width:0] rd_bin;
  logic [adr_width:0] full_cmp;

  assign write       = wr_en && !FIFO_full;
  assign write_adr   = wr_bin;
  assign bin_next    = wr_bin + {{adr_width{1'b0}}, write};
  assign gray_next   = bin_next ^ (bin_next >> 1);
  assign almost_full = (fill_level >= af_thresh);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= adr_width; i++) begin
      rd_bin[i] = ^(rq2 >> i);
    end
  end

  // Full when our next Gray pointer equals the read pointer with its two top bits inverted.
  generate
    if (adr_width == 1) begin : g_small
      assign full_cmp = ~rq2;
    end else begin : g_wide
      assign full_cmp = {~rq2[adr_width:adr_width-1], rq2[adr_width-2:0]};
    end
  endgenerate

  always_ff @(posedge clk_w or negedge reset) begin
    if (!reset) begin
      rq1         <= '0;
      rq2         <= '0;
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      FIFO_full   <= 1'b0;
      fill_level  <= '0;
      overflow    <= 1'b0;
    end else begin
      rq1         <= rd_ptr_gray;
      rq2         <= rq1;
      wr_bin      <= bin_next;
      wr_ptr_gray <= gray_next;
      FIFO_full   <= (gray_next == full_cmp);
      fill_level  <= bin_next - rd_bin;
      // A set request takes priority over a simultaneous clear.
      if (wr_en && FIFO_full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
